piso_serializer: RTL and testbench
==================================

Name:
piso_serializer

Overview:
- Parametrised parallel-in/serial-out serializer: successor to the fixed 10-bit PISO used behind the 8b/10b encoder.
- Accepts WIDTH-bit words over a valid/ready handshake into a one-word holding buffer, so back-to-back words stream with no idle gap.
- Shifts LSB- or MSB-first at a rate set by a bit-clock enable.
- Flags frame boundaries for downstream link/comma logic.

Parameters:
- WIDTH, 10: word width in bits, ≥2.
- LSB_FIRST, 1: 1 sends bit 0 first; 0 sends bit WIDTH-1 first.
- IDLE_LEVEL, 0: serial_out level when no frame is being sent.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- bit_en  in  1  bit-rate enable; one serial bit advances per clk edge with bit_en=1
- in_valid  in  1  in_data valid
- in_ready  out  1  holding buffer empty; word accepted on a clk edge with in_valid & in_ready
- in_data  in  WIDTH  parallel word
- serial_out  out  1  serial bit stream
- serial_valid  out  1  high while serial_out carries a data bit
- frame_start  out  1  high while the first bit of a word is on serial_out
- frame_done  out  1  one-clk pulse on the edge that retires the last bit of a word
- busy  out  1  serial_valid | ~in_ready

Behaviour:
- Registers:
  - hold_reg[WIDTH] and hold_valid
  - shift_reg[WIDTH]
  - cnt, $clog2(WIDTH) bits
  - state ∈ {IDLE, SHIFT}
- Reset: state=IDLE, hold_valid=0, shift_reg=0, cnt=0, frame_done=0. Outputs during reset: in_ready=1, serial_out=IDLE_LEVEL, serial_valid=0, frame_start=0, busy=0.
- Reset mid-frame aborts the current word and discards any buffered word; there is no partial-frame completion and no frame_done.
- Handshake:
  - in_ready = ~hold_valid, from registers only, with no combinational path from in_valid.
  - Acceptance is independent of bit_en.
  - in_data is ignored when in_valid=0 or in_ready=0.
- Output decode:
  - serial_out = (state==SHIFT) ? (LSB_FIRST ? shift_reg[0] : shift_reg[WIDTH-1]) : IDLE_LEVEL.
  - serial_valid = (state==SHIFT).
  - frame_start = serial_valid & (cnt==0).
- Edges with bit_en=0: state, shift_reg and cnt hold; frame_done=0.
- IDLE, bit_en=1, hold_valid=1: shift_reg←hold_reg, hold_valid←0, cnt←0, state←SHIFT.
- SHIFT, bit_en=1, cnt<WIDTH-1: shift by one toward the output end, zero-filling; cnt←cnt+1.
- SHIFT, bit_en=1, cnt==WIDTH-1: frame_done←1 for one clk.
  - If hold_valid=1: reload from hold_reg, cnt←0, stay in SHIFT. The next word is gapless and frame_start rises immediately.
  - Else: state←IDLE.
- Simultaneous events:
  - If the hold buffer is released on an edge while in_valid=1, in_ready was 0 on that edge, so nothing is accepted. The new word is accepted on the following edge.
  - A word accepted on an edge where IDLE & bit_en=1 goes into hold only. It loads on the next bit_en edge.
- Latency with bit_en tied high:
  - Word accepted at edge k, loaded at k+1.
  - Bit 0 is on serial_out from k+1 to k+2.
  - Last bit from k+WIDTH to k+WIDTH+1; frame_done is high after edge k+WIDTH+1.
- Throughput: one word per WIDTH bit_en ticks when in_valid is held high.
- No output depends combinationally on in_valid or in_data.

Decomposition:
- Shared package serdes_pkg: state encoding (ST_IDLE, ST_SHIFT), the CNT_W computation helper, default WIDTH=10 constant for the 8b/10b path.
- One natural sub-module: piso_hold_buf, the one-word valid/ready holding register (hold_reg, hold_valid, in_ready). The shift FSM stays in the top module.

Test Plan:
- Single word, WIDTH=10, LSB_FIRST=1, bit_en=1, in_data=10'b1100000101 → serial_out bits 1,0,1,0,0,0,0,0,1,1 on successive cycles.
  - frame_start is high on the first bit only.
  - frame_done pulses once after the tenth bit, then serial_out=IDLE_LEVEL and busy=0.
- Back-to-back 0x17C then 0x283, in_valid held high → 20 consecutive valid bits with no gap, two frame_start assertions 10 cycles apart, in_ready low except on acceptance edges.
- LSB_FIRST=0, WIDTH=8, in_data=8'hA5 → serial_out 1,0,1,0,0,1,0,1.
- bit_en pattern 1,0,0 repeating, in_data=10'h3FF → each bit lasts 3 clk. Handshake still accepts a second word during shifting while the hold buffer is empty.
- Assert reset at bit 4 of one frame with a second word buffered → all outputs at reset values asynchronously, no frame_done. After release with in_valid=0, serial_out stays at IDLE_LEVEL.
- in_valid toggled while in_ready=0 with changing in_data → only accepted words appear on serial_out; the output word sequence matches a reference queue model.

Source files
------------

// File: rtl/serdes_pkg.sv
// serdes_pkg: shared types and constants for the serializer path
package serdes_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 10;

    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/piso_serializer_hold_buf.sv
// piso_hold_buf: one-word valid/ready holding register feeding the shifter
module piso_hold_buf
    import serdes_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             take,
    output logic             in_ready,
    output logic             hold_valid,
    output logic [WIDTH-1:0] hold_reg
);

    assign in_ready = ~hold_valid;

    // release wins: a full buffer never accepts, so take and accept cannot coincide
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_reg   <= '0;
        end else if (take) begin
            hold_valid <= 1'b0;
        end else if (in_valid && !hold_valid) begin
            hold_valid <= 1'b1;
            hold_reg   <= in_data;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parametrised parallel-in/serial-out shifter with gapless word reload
module piso_serializer
    import serdes_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit LSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);

    localparam int              CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state, state_nx;
    logic [WIDTH-1:0]   shift_reg, shift_nx, hold_reg;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               hold_valid, done_nx, last, load;

    assign last = cnt == LAST;
    assign load = bit_en & hold_valid & ((state == ST_IDLE) | last);

    piso_hold_buf #(.WIDTH(WIDTH)) u_hold (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .take       (load),
        .in_ready   (in_ready),
        .hold_valid (hold_valid),
        .hold_reg   (hold_reg)
    );

    // state register: shifter, bit counter and the frame_done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            shift_reg  <= '0;
            cnt        <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            shift_reg  <= shift_nx;
            cnt        <= cnt_nx;
            frame_done <= done_nx;
        end
    end

    // next state: load a held word, shift toward the output end, or retire the frame
    always_comb begin
        state_nx = state;
        shift_nx = shift_reg;
        cnt_nx   = cnt;
        done_nx  = 1'b0;
        if (bit_en) begin
            if (load) begin
                shift_nx = hold_reg;
                cnt_nx   = '0;
                state_nx = ST_SHIFT;
            end else if (state == ST_SHIFT && !last) begin
                shift_nx = LSB_FIRST ? shift_reg >> 1 : shift_reg << 1;
                cnt_nx   = cnt + CNT_W'(1);
            end else if (state == ST_SHIFT) begin
                state_nx = ST_IDLE;
            end
            done_nx = (state == ST_SHIFT) && last;
        end
    end

    // output decode from registers only
    always_comb begin
        serial_valid = state == ST_SHIFT;
        serial_out   = serial_valid ? (LSB_FIRST ? shift_reg[0] : shift_reg[WIDTH-1]) : IDLE_LEVEL;
        frame_start  = serial_valid & (cnt == '0);
        busy         = serial_valid | ~in_ready;
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: randomized and directed checks against a word/bit-index reference model
module tb_piso_serializer;

    localparam int W = 10;

    logic clk = 1'b0, reset = 1'b1, bit_en = 1'b1, in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic a_in_ready, a_serial_out, a_serial_valid, a_frame_start, a_frame_done, a_busy;

    logic b_en = 1'b1, b_valid = 1'b0;
    logic [7:0] b_data = '0, b_exp = 8'hA5;
    logic b_ready, b_out, b_sv, b_fs, b_fd, b_busy;

    int checks = 0, failures = 0, mode = 0, ph = 0, fd_cnt = 0, run = 0, max_run = 0, fd0 = 0, n = 0;

    logic m_hv = 1'b0, m_act = 1'b0, m_fd = 1'b0, m_acc, m_rel;
    logic [W-1:0] m_hd = '0, m_word = '0, cap = '0, exp_w;
    int m_idx = 0, ncap = 0;
    logic [W-1:0] q[$];
    logic snap_out = 1'b0, snap_valid = 1'b0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .reset(reset), .bit_en(bit_en), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .serial_out(a_serial_out), .serial_valid(a_serial_valid),
        .frame_start(a_frame_start), .frame_done(a_frame_done), .busy(a_busy)
    );

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_b (
        .clk(clk), .reset(reset), .bit_en(b_en), .in_valid(b_valid), .in_ready(b_ready),
        .in_data(b_data), .serial_out(b_out), .serial_valid(b_sv),
        .frame_start(b_fs), .frame_done(b_fd), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // bit-rate enable: always on, 1-0-0 pattern, or random
    always @(negedge clk) begin
        if (mode == 0) bit_en = 1'b1;
        else if (mode == 1) begin
            bit_en = (ph == 0);
            ph = (ph + 1) % 3;
        end else bit_en = ($urandom % 4) != 0;
    end

    // per-cycle output comparison against the model
    always @(negedge clk) begin
        snap_out   = a_serial_out;
        snap_valid = a_serial_valid;
        check("in_ready", a_in_ready, !m_hv);
        check("serial_out", a_serial_out, m_act ? m_word[m_idx] : 1'b0);
        check("serial_valid", a_serial_valid, m_act);
        check("frame_start", a_frame_start, m_act && m_idx == 0);
        check("frame_done", a_frame_done, m_fd);
        check("busy", a_busy, m_act | m_hv);
        if (a_frame_done) fd_cnt++;
        run = a_serial_valid ? run + 1 : 0;
        if (run > max_run) max_run = run;
    end

    // reference model: accepted-word queue, held word, active word and bit index
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hv = 1'b0; m_act = 1'b0; m_fd = 1'b0; m_idx = 0; ncap = 0;
            q.delete();
        end else begin
            if (snap_valid && bit_en) begin
                cap = {snap_out, cap[W-1:1]};
                ncap++;
                if (ncap == W) begin
                    exp_w = (q.size() != 0) ? q.pop_front() : ~cap;
                    check("sb_word", cap, exp_w);
                    ncap = 0;
                end
            end
            m_acc = in_valid && !m_hv;
            m_rel = 1'b0;
            m_fd  = 1'b0;
            if (bit_en) begin
                if (m_act) begin
                    if (m_idx == W - 1) begin
                        m_fd = 1'b1;
                        if (m_hv) begin m_word = m_hd; m_idx = 0; m_rel = 1'b1; end
                        else m_act = 1'b0;
                    end else m_idx++;
                end else if (m_hv) begin
                    m_act = 1'b1; m_word = m_hd; m_idx = 0; m_rel = 1'b1;
                end
            end
            if (m_rel) m_hv = 1'b0;
            else if (m_acc) begin
                m_hv = 1'b1; m_hd = in_data; q.push_back(in_data);
            end
        end
    end

    task automatic send(input logic [W-1:0] d);
        int k = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!a_in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("send_ready", a_in_ready, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", a_in_ready, 1'b1);
        check("rst_out", a_serial_out, 1'b0);
        check("rst_busy", a_busy, 1'b0);
        check("rst_b_out", b_out, 1'b1);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        fd0 = fd_cnt;
        send(10'b1100000101);
        in_valid = 1'b0;
        repeat (14) @(negedge clk);
        check("single_fd", fd_cnt - fd0, 1);
        check("single_idle", a_serial_out, 1'b0);
        check("single_busy", a_busy, 1'b0);

        b_valid = 1'b1;
        b_data  = 8'hA5;
        @(negedge clk);
        b_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("msb_bit", b_out, b_exp[7-i]);
            check("msb_fs", b_fs, i == 0);
        end
        @(negedge clk);
        check("msb_idle", b_out, 1'b1);
        check("msb_sv", b_sv, 1'b0);

        max_run = 0;
        fd0 = fd_cnt;
        send(10'h17C);
        send(10'h283);
        in_valid = 1'b0;
        repeat (25) @(negedge clk);
        check("b2b_run", max_run, 20);
        check("b2b_fd", fd_cnt - fd0, 2);

        ph = 0;
        mode = 1;
        max_run = 0;
        send(10'h3FF);
        send(10'h2A5);
        in_valid = 1'b0;
        repeat (80) @(negedge clk);
        check("slow_run", max_run, 60);
        mode = 0;
        @(negedge clk);

        fd0 = fd_cnt;
        send(10'h155);
        send(10'h0AA);
        in_valid = 1'b0;
        n = 0;
        while (!(m_act && m_idx == 4) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach", m_act && m_idx == 4 && m_hv, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("arst_ready", a_in_ready, 1'b1);
        check("arst_out", a_serial_out, 1'b0);
        check("arst_sv", a_serial_valid, 1'b0);
        check("arst_fs", a_frame_start, 1'b0);
        check("arst_fd", a_frame_done, 1'b0);
        check("arst_busy", a_busy, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("post_rst_out", a_serial_out, 1'b0);
        check("post_rst_sv", a_serial_valid, 1'b0);
        check("post_rst_fd", fd_cnt - fd0, 0);

        mode = 2;
        repeat (600) begin
            in_valid = 1'($urandom % 2);
            in_data  = W'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        mode = 0;
        repeat (30) @(negedge clk);
        check("drain_q", q.size(), 0);
        check("drain_busy", a_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
